cpu_sequencer: RTL and testbench

Clocked successor to the accumulator CPU's combinational phase decoder. It owns the 8-phase instruction cycle counter, decodes control strobes from phase and opcode, and adds halt/resume, single-step, illegal-opcode trapping, a retired-instruction counter and optional memory wait states. It sits between the instruction register/ALU flags and the datapath control inputs.

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/cpu_sequencer_if.sv | 39 +++
 rtl/cpu_sequencer_ctrl_decode.sv | 58 +++++
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode/phase encodings, sequencer state type and the strobe bundle
// used by the cpu_sequencer and its decode sub-module.
package cpu_ctrl_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  typedef enum logic [1:0] {RUN, HALTED, STEP_WAIT} seq_state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } strobes_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/strobe bundle between the sequencer and its surroundings.
// mem_ready exists only when SEQ_MEM_WAIT_EN is defined.
interface cpu_sequencer_if #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
);
  logic                enable;
  logic                step_mode;
  logic                step_req;
  logic                resume;
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
`ifdef SEQ_MEM_WAIT_EN
  logic                mem_ready;
`endif
  logic                sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0]          phase;
  logic                halted;
  logic                illegal;
  logic [CNT_W-1:0]    instr_count;

  modport master (
`ifdef SEQ_MEM_WAIT_EN
    output mem_ready,
`endif
    output enable, step_mode, step_req, resume, opcode, zero,
    input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
    input  phase, halted, illegal, instr_count
  );

  modport slave (
`ifdef SEQ_MEM_WAIT_EN
    input  mem_ready,
`endif
    input  enable, step_mode, step_req, resume, opcode, zero,
    output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
    output phase, halted, illegal, instr_count
  );
endinterface

// File: rtl/cpu_sequencer_ctrl_decode.sv
// Combinational strobe decode from sequencer state, phase, opcode and zero flag.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic       rst,
  input  seq_state_t state,
  input  logic [2:0] phase,
  input  logic [2:0] op,
  input  logic       op_illegal,
  input  logic       zero,
  output strobes_t   strb
);
  logic alu, is_hlt, is_skz, is_sto, is_jmp;

  assign alu    = is_aluop(op) && !op_illegal;
  assign is_hlt = (op == HLT) && !op_illegal;
  assign is_skz = (op == SKZ) && !op_illegal;
  assign is_sto = (op == STO) && !op_illegal;
  assign is_jmp = (op == JMP) && !op_illegal;

  always_comb begin
    strb = '0;
    if (!rst && state == HALTED) begin
      strb.halt = 1'b1;
    end else if (!rst && state == RUN) begin
      case (phase)
        INST_ADDR:  strb.sel = 1'b1;
        INST_FETCH: begin
          strb.sel = 1'b1;
          strb.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          strb.sel   = 1'b1;
          strb.rd    = 1'b1;
          strb.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          strb.inc_pc = 1'b1;
          strb.halt   = is_hlt || op_illegal;
        end
        OP_FETCH:   strb.rd = alu;
        ALU_OP: begin
          strb.rd     = alu;
          strb.inc_pc = is_skz && zero;
          strb.ld_pc  = is_jmp;
          strb.data_e = is_sto;
        end
        STORE: begin
          strb.rd     = alu;
          strb.ld_ac  = alu;
          strb.ld_pc  = is_jmp;
          strb.data_e = is_sto;
          strb.wr     = is_sto;
        end
      endcase
    end
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Clocked instruction sequencer: phase counter, halt/step FSM, illegal trap,
// retire counter. Define SEQ_MEM_WAIT_EN to enable mem_ready wait states.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  cpu_sequencer_if.slave bus
);
  seq_state_t       state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       op;
  logic             op_illegal;
  logic             stall;
  strobes_t         strb;

  assign op = bus.opcode[2:0];

  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign op_illegal = |bus.opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign op_illegal = 1'b0;
    end
  endgenerate

`ifdef SEQ_MEM_WAIT_EN
  logic alu_op;
  assign alu_op = is_aluop(op) && !op_illegal;

  // Memory-touching phases hold until the memory answers.
  always_comb begin
    stall = 1'b0;
    if (state_q == RUN && !bus.mem_ready) begin
      case (phase_q)
        INST_FETCH: stall = 1'b1;
        OP_FETCH:   stall = alu_op;
        STORE:      stall = alu_op || (op == STO && !op_illegal);
        default:    stall = 1'b0;
      endcase
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      phase_q   <= INST_ADDR;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    if (bus.enable) begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            if (phase_q == OP_ADDR && (op == HLT || op_illegal)) begin
              phase_d = OP_FETCH;
              state_d = HALTED;
              if (op_illegal) illegal_d = 1'b1;
            end else begin
              phase_d = phase_q + 3'd1;
              if (phase_q == STORE) begin
                count_d = count_q + 1'b1;
                if (bus.step_mode) state_d = STEP_WAIT;
              end
            end
          end
        end
        HALTED: begin
          if (bus.resume) begin
            phase_d   = INST_ADDR;
            state_d   = RUN;
            illegal_d = 1'b0;
          end
        end
        STEP_WAIT: begin
          // A step request consumes the phase-0 slot, so execution resumes at phase 1.
          if (bus.step_req) begin
            state_d = RUN;
            phase_d = INST_FETCH;
          end else if (!bus.step_mode) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  ctrl_decode u_decode (
    .rst       (rst),
    .state     (state_q),
    .phase     (phase_q),
    .op        (op),
    .op_illegal(op_illegal),
    .zero      (bus.zero),
    .strb      (strb)
  );

  assign bus.sel         = strb.sel;
  assign bus.rd          = strb.rd;
  assign bus.ld_ir       = strb.ld_ir;
  assign bus.inc_pc      = strb.inc_pc;
  assign bus.halt        = strb.halt;
  assign bus.ld_pc       = strb.ld_pc;
  assign bus.data_e      = strb.data_e;
  assign bus.ld_ac       = strb.ld_ac;
  assign bus.wr          = strb.wr;
  assign bus.phase       = phase_q;
  assign bus.halted      = (state_q == HALTED);
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-phase strobe table, hand sequences for halt,
// illegal, step and wait states, then random stimulus against a reference model.
module tb_cpu_sequencer;
  localparam int OW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.OPCODE_W(OW), .CNT_W(CW)) bus ();
  cpu_sequencer #(.OPCODE_W(OW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  // Reference model state: 0 run, 1 halted, 2 waiting for a step.
  int         m_st, m_ph;
  bit         m_ill;
  logic [15:0] m_cnt;

  typedef struct {
    logic [3:0] op;
    bit         z;
    int         ph;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] strb();
    return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt, bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};
  endfunction

  // Bits: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  function automatic logic [8:0] ref_strobes(input int ph, input int op, input bit z);
    logic [8:0] s = '0;
    bit ill = (op >= 8);
    bit alu = (op >= 2 && op <= 5);
    case (ph)
      0: s[8] = 1'b1;
      1: s[8:7] = 2'b11;
      2, 3: s[8:6] = 3'b111;
      4: begin s[5] = 1'b1; s[4] = (op == 0) || ill; end
      5: s[7] = alu;
      6: begin s[7] = alu; s[5] = (op == 1) && z; s[3] = (op == 7); s[2] = (op == 6); end
      7: begin s[7] = alu; s[1] = alu; s[3] = (op == 7); s[2] = (op == 6); s[0] = (op == 6); end
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_ill = 1'b0; m_cnt = '0;
  endtask

  task automatic model_step();
    int op = int'(bus.opcode);
    bit ill = (op >= 8);
    bit alu = (op >= 2 && op <= 5);
    bit stl = 1'b0;
`ifdef SEQ_MEM_WAIT_EN
    stl = (m_st == 0) && !bus.mem_ready &&
          (m_ph == 1 || (m_ph == 5 && alu) || (m_ph == 7 && (alu || op == 6)));
`endif
    if (rst) begin
      model_reset();
    end else if (bus.enable) begin
      if (m_st == 0) begin
        if (!stl) begin
          if (m_ph == 4 && (op == 0 || ill)) begin
            m_ph = 5; m_st = 1;
            if (ill) m_ill = 1'b1;
          end else if (m_ph == 7) begin
            m_ph = 0; m_cnt = m_cnt + 16'd1;
            if (bus.step_mode) m_st = 2;
          end else begin
            m_ph = m_ph + 1;
          end
        end
      end else if (m_st == 1) begin
        if (bus.resume) begin m_ph = 0; m_st = 0; m_ill = 1'b0; end
      end else begin
        if (bus.step_req) begin m_st = 0; m_ph = 1; end
        else if (!bus.step_mode) m_st = 0;
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic init_inputs();
    bus.enable = 1'b1; bus.step_mode = 1'b0; bus.step_req = 1'b0; bus.resume = 1'b0;
    bus.opcode = '0; bus.zero = 1'b0;
`ifdef SEQ_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_strobes", 64'(strb()), 64'(9'h000));
    nxt();
    rst = 1'b0;
    #1;
    check("reset_state", {strb(), bus.phase, bus.halted, bus.illegal, bus.instr_count},
          {9'h100, 3'd0, 1'b0, 1'b0, 16'd0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    init_inputs();

    tbl.push_back('{4'd5, 1'b0, 0, 9'h100});
    tbl.push_back('{4'd5, 1'b0, 1, 9'h180});
    tbl.push_back('{4'd5, 1'b0, 2, 9'h1C0});
    tbl.push_back('{4'd5, 1'b0, 3, 9'h1C0});
    tbl.push_back('{4'd5, 1'b0, 4, 9'h020});
    tbl.push_back('{4'd5, 1'b0, 5, 9'h080});
    tbl.push_back('{4'd5, 1'b0, 6, 9'h080});
    tbl.push_back('{4'd5, 1'b0, 7, 9'h082});
    tbl.push_back('{4'd1, 1'b1, 4, 9'h020});
    tbl.push_back('{4'd1, 1'b1, 6, 9'h020});
    tbl.push_back('{4'd1, 1'b1, 7, 9'h000});
    tbl.push_back('{4'd1, 1'b0, 4, 9'h020});
    tbl.push_back('{4'd1, 1'b0, 6, 9'h000});
    tbl.push_back('{4'd7, 1'b0, 6, 9'h008});
    tbl.push_back('{4'd7, 1'b0, 7, 9'h008});
    tbl.push_back('{4'd6, 1'b0, 5, 9'h000});
    tbl.push_back('{4'd6, 1'b0, 6, 9'h004});
    tbl.push_back('{4'd6, 1'b0, 7, 9'h005});
    tbl.push_back('{4'd0, 1'b0, 4, 9'h030});
    tbl.push_back('{4'd2, 1'b1, 7, 9'h082});
    tbl.push_back('{4'd3, 1'b0, 6, 9'h080});
    tbl.push_back('{4'd4, 1'b0, 5, 9'h080});
    tbl.push_back('{4'hA, 1'b0, 4, 9'h030});

    foreach (tbl[i]) begin
      init_inputs();
      bus.opcode = tbl[i].op;
      bus.zero   = tbl[i].z;
      do_reset();
      repeat (tbl[i].ph) nxt();
      check($sformatf("tbl%0d_phase", i), 64'(bus.phase), 64'(tbl[i].ph));
      check($sformatf("tbl%0d_strobes", i), 64'(strb()), 64'(tbl[i].exp));
    end

    // LDA: full instruction, with a frozen stretch at phase 6.
    init_inputs();
    bus.opcode = 4'd5;
    do_reset();
    repeat (6) nxt();
    bus.enable = 1'b0;
    repeat (3) nxt();
    check("freeze", {strb(), bus.phase}, {9'h080, 3'd6});
    bus.enable = 1'b1;
    repeat (2) nxt();
    check("lda_retire", {strb(), bus.phase, bus.instr_count}, {9'h100, 3'd0, 16'd1});

    // HLT: halt strobe at phase 4, halted one cycle later, resume to phase 0.
    init_inputs();
    bus.opcode = 4'd0;
    do_reset();
    repeat (4) nxt();
    check("hlt_p4", {strb(), bus.halted}, {9'h030, 1'b0});
    nxt();
    check("hlt_enter", {strb(), bus.phase, bus.halted}, {9'h010, 3'd5, 1'b1});
    for (int c = 0; c < 20; c++) begin
      nxt();
      check("hlt_hold", {strb(), bus.phase, bus.halted}, {9'h010, 3'd5, 1'b1});
    end
    bus.resume = 1'b1;
    nxt();
    bus.resume = 1'b0;
    check("hlt_resume", {strb(), bus.phase, bus.halted}, {9'h100, 3'd0, 1'b0});

    // Illegal opcode traps, resume clears the sticky flag.
    init_inputs();
    bus.opcode = 4'hA;
    do_reset();
    repeat (4) nxt();
    check("ill_p4", {strb(), bus.illegal}, {9'h030, 1'b0});
    nxt();
    check("ill_trap", {bus.phase, bus.halted, bus.illegal}, {3'd5, 1'b1, 1'b1});
    bus.resume = 1'b1;
    nxt();
    bus.resume = 1'b0;
    check("ill_clear", {bus.phase, bus.halted, bus.illegal}, {3'd0, 1'b0, 1'b0});

    // Single-step JMP.
    init_inputs();
    bus.opcode = 4'd7;
    bus.step_mode = 1'b1;
    do_reset();
    repeat (8) nxt();
    check("step_enter", {strb(), bus.phase, bus.instr_count}, {9'h000, 3'd0, 16'd1});
    for (int c = 0; c < 10; c++) begin
      nxt();
      check("step_wait", {strb(), bus.phase}, {9'h000, 3'd0});
    end
    bus.step_req = 1'b1;
    nxt();
    bus.step_req = 1'b0;
    check("step_go", {strb(), bus.phase}, {9'h180, 3'd1});
    repeat (7) nxt();
    check("step_again", {strb(), bus.phase, bus.instr_count}, {9'h000, 3'd0, 16'd2});
    bus.step_mode = 1'b0;
    nxt();
    check("step_exit", {strb(), bus.phase}, {9'h100, 3'd0});
    nxt();
    check("step_run", 64'(bus.phase), 64'(1));

`ifdef SEQ_MEM_WAIT_EN
    // STO stalls at phase 7 for three cycles, then reset during an ALU fetch stall.
    init_inputs();
    bus.opcode = 4'd6;
    do_reset();
    repeat (6) nxt();
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nxt();
      check("mw_hold", {strb(), bus.phase}, {9'h005, 3'd7});
    end
    bus.mem_ready = 1'b1;
    #1;
    check("mw_last", {strb(), bus.phase}, {9'h005, 3'd7});
    nxt();
    check("mw_retire", {bus.phase, bus.instr_count}, {3'd0, 16'd1});
    bus.opcode = 4'd5;
    repeat (5) nxt();
    bus.mem_ready = 1'b0;
    nxt();
    check("mw_alu_hold", {strb(), bus.phase}, {9'h080, 3'd5});
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #1;
    check("mw_rst", {bus.phase, bus.instr_count}, {3'd0, 16'd0});
    bus.mem_ready = 1'b1;
`endif

    // Random stimulus against the reference model.
    init_inputs();
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] exp;
      int op;
      rst = ($urandom % 97 == 0);
      bus.enable = ($urandom % 8 != 0);
      if ($urandom % 50 == 0) bus.step_mode = ~bus.step_mode;
      bus.step_req = ($urandom % 6 == 0);
      bus.resume = ($urandom % 8 == 0);
      bus.zero = $urandom % 2;
      op = $urandom % 16;
      if (op >= 8 && $urandom % 4 != 0) op = op - 8;
      if (op == 0 && $urandom % 2 == 0) op = 5;
      bus.opcode = op[3:0];
`ifdef SEQ_MEM_WAIT_EN
      bus.mem_ready = ($urandom % 4 != 0);
`endif
      #1;
      if (rst) exp = 9'h000;
      else if (m_st == 1) exp = 9'h010;
      else if (m_st == 2) exp = 9'h000;
      else exp = ref_strobes(m_ph, op, bus.zero);
      check("rand_cycle", {strb(), bus.phase, bus.halted, bus.illegal, bus.instr_count},
            {exp, m_ph[2:0], m_st == 1, m_ill, m_cnt});
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
